// File: rtl/onchip_memory_dp.sv
// onchip_memory_dp: dual-port byte-lane memory with power-up clear FSM; define ONCHIP_MEMORY_DP_FWD_EN for write-first cross-port reads
module onchip_memory_dp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 128000,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W/8-1:0] byteenable_a,
    input  logic              chipselect_a,
    input  logic              read_a,
    input  logic              write_a,
    input  logic [DATA_W-1:0] writedata_a,
    output logic [DATA_W-1:0] readdata_a,
    output logic              readdatavalid_a,
    output logic              waitrequest_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W/8-1:0] byteenable_b,
    input  logic              chipselect_b,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [DATA_W-1:0] writedata_b,
    output logic [DATA_W-1:0] readdata_b,
    output logic              readdatavalid_b,
    output logic              waitrequest_b,
    output logic              init_done
);
    localparam int BE_W = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] addr  [2];
    logic [BE_W-1:0]   be    [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        cs, rd, wr;
    logic              busy;
    logic [1:0]        in_rng, rd_acc, wr_acc;
    logic [IDX_W-1:0]  idx   [2];
    logic [BE_W-1:0]   wl    [2];
    logic [DATA_W-1:0] rword [2];

    logic [READ_LAT-1:0] pv_q [2];
    logic [DATA_W-1:0]   pd_q [2][READ_LAT];

    assign addr[0]  = address_a;
    assign addr[1]  = address_b;
    assign be[0]    = byteenable_a;
    assign be[1]    = byteenable_b;
    assign wdata[0] = writedata_a;
    assign wdata[1] = writedata_b;
    assign cs       = {chipselect_b, chipselect_a};
    assign rd       = {read_b, read_a};
    assign wr       = {write_b, write_a};
    assign busy     = reset | ~clken | (state_q != READY);

    // Decode requests: a simultaneous read+write is a write; out-of-range writes get no lanes
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = {1'b0, addr[p]} < DEPTH_X;
            idx[p]    = addr[p][IDX_W-1:0];
            rd_acc[p] = cs[p] & rd[p] & ~wr[p] & ~busy;
            wr_acc[p] = cs[p] & wr[p] & ~busy & in_rng[p];
            wl[p]     = wr_acc[p] ? be[p] : '0;
        end
    end

    // Read word per port; out-of-range reads return zero, optionally merged with the other port's write
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rword[p] = in_rng[p] ? mem_q[idx[p]] : '0;
`ifdef ONCHIP_MEMORY_DP_FWD_EN
            for (int l = 0; l < BE_W; l++)
                if (in_rng[p] && idx[1-p] == idx[p] && wl[1-p][l])
                    rword[p][8*l +: 8] = wdata[1-p][8*l +: 8];
`endif
        end
    end

    // Clear sequencer next state: one word per enabled cycle, READY after the last word
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (clken && state_q == CLEAR) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(DEPTH - 1))
                state_d = READY;
        end
    end

    // Clear sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory array: clear word, then lane writes with port a applied last so it wins overlaps
    always_ff @(posedge clk) begin
        if (clken && !reset) begin
            if (state_q == CLEAR)
                mem_q[ptr_q] <= '0;
            for (int p = 1; p >= 0; p--)
                for (int l = 0; l < BE_W; l++)
                    if (wl[p][l])
                        mem_q[idx[p]][8*l +: 8] <= wdata[p][8*l +: 8];
        end
    end

    // Read pipeline: valid shifts every enabled cycle, data only advances with a valid
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                pv_q[p] <= '0;
                for (int i = 0; i < READ_LAT; i++)
                    pd_q[p][i] <= '0;
            end
        end else if (clken) begin
            for (int p = 0; p < 2; p++) begin
                pv_q[p][0] <= rd_acc[p];
                pd_q[p][0] <= rd_acc[p] ? rword[p] : pd_q[p][0];
                for (int i = 1; i < READ_LAT; i++) begin
                    pv_q[p][i] <= pv_q[p][i-1];
                    pd_q[p][i] <= pv_q[p][i-1] ? pd_q[p][i-1] : pd_q[p][i];
                end
            end
        end
    end

    assign readdata_a      = reset ? '0 : pd_q[0][READ_LAT-1];
    assign readdata_b      = reset ? '0 : pd_q[1][READ_LAT-1];
    assign readdatavalid_a = pv_q[0][READ_LAT-1] & clken & ~reset;
    assign readdatavalid_b = pv_q[1][READ_LAT-1] & clken & ~reset;
    assign waitrequest_a   = busy;
    assign waitrequest_b   = busy;
    assign init_done       = (state_q == READY) & ~reset;
endmodule

// File: doc/onchip_memory_dp.md
ONCHIP_MEMORY_DP -- requirements
Module: onchip_memory_dp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data width in bits (multiple of 8).
REQ-002 SHALL provide parameter ADDR_W, default 17, word address width.
REQ-003 SHALL provide parameter DEPTH, default 128000, number of words (DEPTH <= 2^ADDR_W).
REQ-004 SHALL provide parameter READ_LAT, default 1, read latency in cycles (legal values 1 or 2).
REQ-005 SHALL derive BE_W = DATA_W/8, not as a user parameter.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 clken  input  1  global clock enable; low freezes all state.
REQ-009 Per port x in {a,b}: address_x  input  ADDR_W  word address.
REQ-010 byteenable_x  input  BE_W  write lane enables.
REQ-011 chipselect_x  input  1  port select.
REQ-012 read_x  input  1  read request.
REQ-013 write_x  input  1  write request.
REQ-014 writedata_x  input  DATA_W  write data.
REQ-015 readdata_x  output  DATA_W  read data.
REQ-016 readdatavalid_x  output  1  one-cycle pulse, readdata_x valid.
REQ-017 waitrequest_x  output  1  request not accepted this cycle.
REQ-018 init_done  output  1  memory cleared and ready.

Function
REQ-019 FSM states CLEAR, READY; reset -> CLEAR with clear pointer 0.
REQ-020 CLEAR: writes all-zero to word[ptr], ptr+1, one word per cycle with clken high; ptr == DEPTH-1 -> READY next cycle.
REQ-021 CLEAR: waitrequest_a = waitrequest_b = 1, init_done = 0; READY: init_done = 1.
REQ-022 waitrequest_x = 1 whenever clken = 0 or state != READY; else 0.
REQ-023 Request accepted on port x when chipselect_x & (read_x | write_x) & !waitrequest_x.
REQ-024 Accepted write: update only lanes with byteenable_x bit set; byteenable_x = 0 is a no-op.
REQ-025 read_x and write_x both high: treated as write only; no readdatavalid_x.
REQ-026 Accepted read: readdata_x and readdatavalid_x = 1 exactly READ_LAT enabled cycles later; readdata_x holds last value otherwise.
REQ-027 Back-to-back reads each cycle: one result per cycle, in order, no bubbles.
REQ-028 address_x >= DEPTH: write dropped; read returns 0 with normal readdatavalid timing.
REQ-029 Both ports write same address same cycle: overlapping lanes take port a data; non-overlapping lanes take their own port's data.
REQ-030 Read on one port, write on other, same address, same cycle: behaviour per REQ-034/035.
REQ-031 clken = 0: no memory update, read pipeline and FSM hold, readdatavalid_x forced 0 that cycle, pending results emitted after clken returns.

Reset
REQ-032 During reset: readdata_x = 0, readdatavalid_x = 0, waitrequest_x = 1, init_done = 0, read pipeline flushed.
REQ-033 Reset mid-CLEAR or mid-read: pending reads discarded (no readdatavalid), clear restarts at address 0.

Configuration
REQ-034 Macro ONCHIP_MEMORY_DP_FWD_EN defined: cross-port same-address collision returns the newly written lane-merged word (write-first).
REQ-035 Macro undefined: colliding read returns the pre-write word (read-first); no forwarding logic present.

Verification (bench DEPTH=16, DATA_W=32)
REQ-036 Reset released, clken=1 -> waitrequest_a/b=1 for 16 cycles, init_done=1 on cycle 17; read of addr 5 returns 0x00000000.
REQ-037 Port a write addr 3 = 0xDEADBEEF, be=4'b0101; then read addr 3 -> 0x00AD00EF after READ_LAT cycles, single readdatavalid_a pulse.
REQ-038 Same cycle port a write addr 7 = 0x11111111 be=4'b0011, port b write addr 7 = 0x22222222 be=4'b0110 -> read gives 0x00221111.
REQ-039 Addr 2 holds 0xAAAAAAAA; port a writes 0x55555555 be=4'hF while port b reads addr 2 -> 0x55555555 with FWD_EN, 0xAAAAAAAA without.
REQ-040 Reads addr 1,2,3 back-to-back with clken low one cycle mid-burst -> three ordered results, readdatavalid_b gap of exactly one cycle.
REQ-041 Reset asserted at clear ptr=8 then released -> full 16-cycle clear repeats; read of addr 16 after init -> 0 with readdatavalid.
